// File: rtl/toggle_event_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | toggle_event_rx : decodes each flip of a toggle-encoded level into an      |
// | event, queues events as a pending count drained by valid/ready.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module toggle_event_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 4,
  parameter int TOTAL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   tgl_in,
  input  logic                   evt_ready,
  output logic                   evt_valid,
  output logic                   edge_pulse,
  output logic [CNT_WIDTH-1:0]   pending,
  output logic [TOTAL_WIDTH-1:0] total,
  output logic                   overflow
);

  localparam logic [CNT_WIDTH-1:0]   c_pend_max = '1;
  localparam logic [CNT_WIDTH-1:0]   c_pend_one = 1;
  localparam logic [TOTAL_WIDTH-1:0] c_tot_one  = 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ref;
  logic                   r_edge_pulse;
  logic [CNT_WIDTH-1:0]   r_pending;
  logic [TOTAL_WIDTH-1:0] r_total;
  logic                   r_overflow;

  logic w_s_out;
  logic w_det;
  logic w_pop;

  assign w_s_out = r_sync[SYNC_STAGES-1];
  assign w_det   = w_s_out ^ r_ref;
  assign w_pop   = evt_valid & evt_ready;

  // Synchroniser chain and reference level; a change relative to the
  // reference is one event.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_sync       <= '0;
      r_ref        <= 1'b0;
      r_edge_pulse <= 1'b0;
    end else if (en) begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], tgl_in};
      r_edge_pulse <= w_det;
      if (w_det) begin
        r_ref <= w_s_out;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_total <= '0;
    end else if (en && w_det) begin
      r_total <= r_total + c_tot_one;
    end
  end

  // Simultaneous arrival and consumption cancel; a full queue drops the
  // new event and latches overflow until reset.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else if (en) begin
      if (w_det && !w_pop) begin
        if (r_pending == c_pend_max) begin
          r_overflow <= 1'b1;
        end else begin
          r_pending <= r_pending + c_pend_one;
        end
      end else if (!w_det && w_pop) begin
        r_pending <= r_pending - c_pend_one;
      end
    end
  end

  assign evt_valid  = (r_pending != '0);
  assign edge_pulse = r_edge_pulse & en;
  assign pending    = r_pending;
  assign total      = r_total;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_toggle_event_rx.sv
`default_nettype none
// Bench for toggle_event_rx: directed scenarios plus random traffic, checked
// per cycle against a queue-fed behavioural model.
module tb_toggle_event_rx;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_WIDTH   = 4;
  localparam int TOTAL_WIDTH = 4;
  localparam int MAXP        = (1 << CNT_WIDTH) - 1;
  localparam int TOT_MOD     = 1 << TOTAL_WIDTH;

  logic                   clk = 1'b0;
  logic                   clr;
  logic                   en;
  logic                   tgl_in;
  logic                   evt_ready;
  logic                   evt_valid;
  logic                   edge_pulse;
  logic [CNT_WIDTH-1:0]   pending;
  logic [TOTAL_WIDTH-1:0] total;
  logic                   overflow;

  toggle_event_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_WIDTH  (CNT_WIDTH),
    .TOTAL_WIDTH(TOTAL_WIDTH)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
    .tgl_in    (tgl_in),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .edge_pulse(edge_pulse),
    .pending   (pending),
    .total     (total),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pend;
    int tot;
    bit ovf;
    bit pulse;
  } rec_t;

  rec_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: levels seen at enabled edges, delayed by the chain depth.
  int m_pending, m_total;
  bit m_ovf, m_pulse, m_ref;
  bit smp[$];
  bit lvl;

  task automatic cmp(input string name, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_pending = 0;
    m_total   = 0;
    m_ovf     = 1'b0;
    m_pulse   = 1'b0;
    m_ref     = 1'b0;
    smp.delete();
    for (int i = 0; i < SYNC_STAGES; i++) smp.push_back(1'b0);
  endtask

  task automatic model_edge(input bit e, input bit t, input bit r);
    bit seen, det, pop;
    if (!e) return;
    seen = smp[0];
    det  = (seen != m_ref);
    pop  = (m_pending != 0) && r;
    if (det) begin
      m_ref   = seen;
      m_total = (m_total + 1) % TOT_MOD;
    end
    if (det && !pop) begin
      if (m_pending == MAXP) m_ovf = 1'b1;
      else                   m_pending++;
    end else if (!det && pop) begin
      m_pending--;
    end
    m_pulse = det;
    void'(smp.pop_front());
    smp.push_back(t);
  endtask

  task automatic step(input bit e, input bit t, input bit r);
    rec_t rec;
    en        = e;
    tgl_in    = t;
    evt_ready = r;
    @(posedge clk);
    #1;
    model_edge(e, t, r);
    rec.pend  = m_pending;
    rec.tot   = m_total;
    rec.ovf   = m_ovf;
    rec.pulse = m_pulse;
    exp_q.push_back(rec);
  endtask

  task automatic toggles(input int n, input int gap, input bit r);
    for (int i = 0; i < n; i++) begin
      lvl = !lvl;
      step(1'b1, lvl, r);
      repeat (gap - 1) step(1'b1, lvl, r);
    end
  endtask

  task automatic settle(input int k, input bit r);
    repeat (k) step(1'b1, lvl, r);
  endtask

  task automatic do_clear();
    @(negedge clk);
    #1;
    clr    = 1'b0;
    tgl_in = 1'b0;
    lvl    = 1'b0;
    #1;
    cmp("clr_valid",    int'(evt_valid),  0);
    cmp("clr_pending",  int'(pending),    0);
    cmp("clr_total",    int'(total),      0);
    cmp("clr_overflow", int'(overflow),   0);
    cmp("clr_pulse",    int'(edge_pulse), 0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    clr = 1'b1;
  endtask

  initial begin : monitor
    rec_t r;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        cmp("pending",    int'(pending),    r.pend);
        cmp("evt_valid",  int'(evt_valid),  (r.pend != 0) ? 1 : 0);
        cmp("total",      int'(total),      r.tot);
        cmp("overflow",   int'(overflow),   int'(r.ovf));
        cmp("edge_pulse", int'(edge_pulse), int'(r.pulse & en));
      end
    end
  end

  initial begin : stimulus
    clr       = 1'b0;
    en        = 1'b0;
    tgl_in    = 1'b0;
    evt_ready = 1'b0;
    lvl       = 1'b0;
    model_reset();
    #12;
    cmp("rst_valid",    int'(evt_valid),  0);
    cmp("rst_pending",  int'(pending),    0);
    cmp("rst_total",    int'(total),      0);
    cmp("rst_overflow", int'(overflow),   0);
    @(negedge clk);
    clr = 1'b1;

    // single toggle, nothing consumed
    toggles(1, 1, 1'b0);
    settle(3, 1'b0);
    cmp("t1_pending", int'(pending), 1);
    cmp("t1_total",   int'(total),   1);

    // five queued, then drained one per cycle
    toggles(4, 4, 1'b0);
    settle(3, 1'b0);
    cmp("t2_pending", int'(pending), 5);
    settle(4, 1'b1);
    cmp("t2_valid_4", int'(evt_valid), 1);
    settle(1, 1'b1);
    cmp("t2_valid_5", int'(evt_valid), 0);

    // arrival coincides with a pop at pending=3
    toggles(3, 4, 1'b0);
    settle(3, 1'b0);
    cmp("t3_pre", int'(pending), 3);
    lvl = !lvl;
    step(1'b1, lvl, 1'b0);
    step(1'b1, lvl, 1'b0);
    step(1'b1, lvl, 1'b1);
    cmp("t3_pending", int'(pending), 3);
    cmp("t3_total",   int'(total),   9);
    settle(3, 1'b1);

    // saturation and sticky overflow
    toggles(16, 3, 1'b0);
    settle(3, 1'b0);
    cmp("t4_pending",  int'(pending),  15);
    cmp("t4_overflow", int'(overflow), 1);
    settle(15, 1'b1);
    cmp("t4_drained",  int'(pending),  0);
    cmp("t4_ovf_hold", int'(overflow), 1);

    // toggle while frozen
    lvl = !lvl;
    repeat (4) step(1'b0, lvl, 1'b1);
    cmp("t5_frozen", int'(total), 9);
    step(1'b1, lvl, 1'b0);
    step(1'b1, lvl, 1'b0);
    cmp("t5_not_yet", int'(total), 9);
    step(1'b1, lvl, 1'b0);
    cmp("t5_total", int'(total),   10);
    cmp("t5_pulse", int'(edge_pulse), 1);
    settle(3, 1'b1);

    // clear mid-queue, then counter wrap
    toggles(16, 3, 1'b0);
    settle(3, 1'b0);
    settle(8, 1'b1);
    cmp("t6_pre", int'(pending), 7);
    do_clear();
    toggles(17, 3, 1'b0);
    settle(3, 1'b0);
    cmp("t6_total",   int'(total),   1);
    cmp("t6_pending", int'(pending), 15);

    // random traffic with occasional clears
    for (int i = 0; i < 3000; i++) begin
      bit e, r;
      e = (($urandom % 8) != 0);
      if (($urandom % 4) == 0) lvl = !lvl;
      r = (($urandom % 2) != 0);
      step(e, lvl, r);
      if (i % 1000 == 999) do_clear();
    end

    settle(4, 1'b0);
    @(negedge clk);
    #1;
    cmp("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
